// File: rtl/execute_stage.sv
// EX stage of a 5-stage RISC-V pipeline: forwarding muxes, single-cycle ALU,
// an iterative shift-add multiplier for MUL/MULHU, and the EX/MEM register.
//
// state | meaning
// IDLE  | single-cycle ops flow through; a MUL/MULHU latches its operands
// BUSY  | one shift-add step per cycle, front end held
// DONE  | product ready, EX/MEM captures it with the ID/EX control fields
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ID_EX_reg_write,
  input  logic            ID_EX_mem_to_reg,
  input  logic            ID_EX_mem_read,
  input  logic            ID_EX_mem_write,
  input  logic [3:0]      ID_EX_alu_op,
  input  logic            ID_EX_alu_src,
  input  logic [XLEN-1:0] ID_EX_dataA,
  input  logic [XLEN-1:0] ID_EX_dataB,
  input  logic [XLEN-1:0] ID_EX_imm,
  input  logic [4:0]      ID_EX_rs1,
  input  logic [4:0]      ID_EX_rs2,
  input  logic [4:0]      ID_EX_rd,
  input  logic            MEM_WB_reg_write,
  input  logic [4:0]      MEM_WB_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  output logic            EX_MEM_reg_write,
  output logic            EX_MEM_mem_to_reg,
  output logic            EX_MEM_mem_read,
  output logic            EX_MEM_mem_write,
  output logic [XLEN-1:0] EX_MEM_alu_out,
  output logic [XLEN-1:0] EX_MEM_dataB,
  output logic [4:0]      EX_MEM_rd,
  output logic            ex_stall
);

  localparam int CW = $clog2(XLEN);
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;

  logic                exm_reg_write_q, exm_reg_write_d;
  logic                exm_mem_to_reg_q, exm_mem_to_reg_d;
  logic                exm_mem_read_q, exm_mem_read_d;
  logic                exm_mem_write_q, exm_mem_write_d;
  logic [XLEN-1:0]     exm_alu_out_q, exm_alu_out_d;
  logic [XLEN-1:0]     exm_dataB_q, exm_dataB_d;
  logic [4:0]          exm_rd_q, exm_rd_d;

  logic [XLEN-1:0]     fwd_a, fwd_b, op_b, alu_res;
  logic [4:0]          shamt;
  logic                is_mul, stall;

  // EX/MEM beats MEM/WB because it holds the younger result; x0 never forwards.
  always_comb begin
    fwd_a = ID_EX_dataA;
    if (exm_reg_write_q && exm_rd_q != 5'd0 && exm_rd_q == ID_EX_rs1)
      fwd_a = exm_alu_out_q;
    else if (MEM_WB_reg_write && MEM_WB_rd != 5'd0 && MEM_WB_rd == ID_EX_rs1)
      fwd_a = wb_data;

    fwd_b = ID_EX_dataB;
    if (exm_reg_write_q && exm_rd_q != 5'd0 && exm_rd_q == ID_EX_rs2)
      fwd_b = exm_alu_out_q;
    else if (MEM_WB_reg_write && MEM_WB_rd != 5'd0 && MEM_WB_rd == ID_EX_rs2)
      fwd_b = wb_data;
  end

  assign op_b   = ID_EX_alu_src ? ID_EX_imm : fwd_b;
  assign shamt  = op_b[4:0];
  assign is_mul = (ID_EX_alu_op == OP_MUL) || (ID_EX_alu_op == OP_MULHU);

  always_comb begin
    alu_res = '0;
    case (ID_EX_alu_op)
      4'd0:    alu_res = fwd_a + op_b;
      4'd1:    alu_res = fwd_a - op_b;
      4'd2:    alu_res = fwd_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
      4'd5:    alu_res = fwd_a ^ op_b;
      4'd6:    alu_res = fwd_a >> shamt;
      4'd7:    alu_res = $signed(fwd_a) >>> shamt;
      4'd8:    alu_res = fwd_a | op_b;
      4'd9:    alu_res = fwd_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          stall    = 1'b1;
          state_d  = S_BUSY;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, fwd_a};
          mplier_d = op_b;
        end
      end
      S_BUSY: begin
        stall    = 1'b1;
        if (mplier_q[0])
          acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush wins over both starting and finishing a multiply.
    if (ex_flush) begin
      stall   = 1'b0;
      state_d = S_IDLE;
    end
    if (reset)
      stall = 1'b0;
  end

  assign ex_stall = stall;

  always_comb begin
    exm_reg_write_d  = ID_EX_reg_write;
    exm_mem_to_reg_d = ID_EX_mem_to_reg;
    exm_mem_read_d   = ID_EX_mem_read;
    exm_mem_write_d  = ID_EX_mem_write;
    exm_alu_out_d    = alu_res;
    exm_dataB_d      = fwd_b;
    exm_rd_d         = ID_EX_rd;
    if (state_q == S_DONE)
      exm_alu_out_d = (ID_EX_alu_op == OP_MULHU) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (stall || ex_flush) begin
      exm_reg_write_d  = 1'b0;
      exm_mem_to_reg_d = 1'b0;
      exm_mem_read_d   = 1'b0;
      exm_mem_write_d  = 1'b0;
      exm_alu_out_d    = '0;
      exm_dataB_d      = '0;
      exm_rd_d         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      acc_q            <= '0;
      mcand_q          <= '0;
      mplier_q         <= '0;
      exm_reg_write_q  <= 1'b0;
      exm_mem_to_reg_q <= 1'b0;
      exm_mem_read_q   <= 1'b0;
      exm_mem_write_q  <= 1'b0;
      exm_alu_out_q    <= '0;
      exm_dataB_q      <= '0;
      exm_rd_q         <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      acc_q            <= acc_d;
      mcand_q          <= mcand_d;
      mplier_q         <= mplier_d;
      exm_reg_write_q  <= exm_reg_write_d;
      exm_mem_to_reg_q <= exm_mem_to_reg_d;
      exm_mem_read_q   <= exm_mem_read_d;
      exm_mem_write_q  <= exm_mem_write_d;
      exm_alu_out_q    <= exm_alu_out_d;
      exm_dataB_q      <= exm_dataB_d;
      exm_rd_q         <= exm_rd_d;
    end
  end

  assign EX_MEM_reg_write  = exm_reg_write_q;
  assign EX_MEM_mem_to_reg = exm_mem_to_reg_q;
  assign EX_MEM_mem_read   = exm_mem_read_q;
  assign EX_MEM_mem_write  = exm_mem_write_q;
  assign EX_MEM_alu_out    = exm_alu_out_q;
  assign EX_MEM_dataB      = exm_dataB_q;
  assign EX_MEM_rd         = exm_rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a cycle-level reference model pushes the
// expected stall and EX/MEM contents; a monitor pops and compares every cycle.
module tb_execute_stage;
  localparam int XLEN = 32;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        reset;
  logic        ID_EX_reg_write, ID_EX_mem_to_reg, ID_EX_mem_read, ID_EX_mem_write;
  logic [3:0]  ID_EX_alu_op;
  logic        ID_EX_alu_src;
  logic [31:0] ID_EX_dataA, ID_EX_dataB, ID_EX_imm;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic        MEM_WB_reg_write;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        EX_MEM_reg_write, EX_MEM_mem_to_reg, EX_MEM_mem_read, EX_MEM_mem_write;
  logic [31:0] EX_MEM_alu_out, EX_MEM_dataB;
  logic [4:0]  EX_MEM_rd;
  logic        ex_stall;

  execute_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_to_reg(ID_EX_mem_to_reg),
    .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
    .ID_EX_alu_op(ID_EX_alu_op), .ID_EX_alu_src(ID_EX_alu_src),
    .ID_EX_dataA(ID_EX_dataA), .ID_EX_dataB(ID_EX_dataB), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .MEM_WB_reg_write(MEM_WB_reg_write), .MEM_WB_rd(MEM_WB_rd), .wb_data(wb_data),
    .ex_flush(ex_flush),
    .EX_MEM_reg_write(EX_MEM_reg_write), .EX_MEM_mem_to_reg(EX_MEM_mem_to_reg),
    .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_write(EX_MEM_mem_write),
    .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_dataB(EX_MEM_dataB), .EX_MEM_rd(EX_MEM_rd),
    .ex_stall(ex_stall)
  );

  typedef struct packed {
    logic        rw, m2r, mr, mw;
    logic [31:0] alu, db;
    logic [4:0]  rd;
  } exm_t;

  typedef struct packed {
    logic stall;
    exm_t exm;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  // Reference model: what EX/MEM should hold, plus multiply progress in cycles.
  exm_t        m_exm = '0;
  int          m_busy = 0;
  bit          m_done = 0;
  bit          m_stall = 0;
  logic [63:0] m_prod = '0;
  logic        obs_stall;

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rv);
    if (m_exm.rw && m_exm.rd != 5'd0 && m_exm.rd == rs) return m_exm.alu;
    if (MEM_WB_reg_write && MEM_WB_rd != 5'd0 && MEM_WB_rd == rs) return wb_data;
    return rv;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Evaluate the model for the inputs currently applied, queue the expectation,
  // then advance one clock.
  task automatic step();
    logic [31:0] a, b2, b;
    exm_t nxt;
    exp_t e;
    a  = fwd(ID_EX_rs1, ID_EX_dataA);
    b2 = fwd(ID_EX_rs2, ID_EX_dataB);
    b  = ID_EX_alu_src ? ID_EX_imm : b2;
    nxt = '0;
    m_stall = 0;
    if (reset || ex_flush) begin
      m_busy = 0;
      m_done = 0;
    end else if (m_busy > 0) begin
      m_stall = 1;
      m_busy--;
      if (m_busy == 0) m_done = 1;
    end else if (m_done) begin
      nxt = '{ID_EX_reg_write, ID_EX_mem_to_reg, ID_EX_mem_read, ID_EX_mem_write,
              (ID_EX_alu_op == 4'd12) ? m_prod[63:32] : m_prod[31:0], b2, ID_EX_rd};
      m_done = 0;
    end else if (ID_EX_alu_op == 4'd11 || ID_EX_alu_op == 4'd12) begin
      m_stall = 1;
      m_prod  = {32'd0, a} * {32'd0, b};
      m_busy  = XLEN;
    end else begin
      nxt = '{ID_EX_reg_write, ID_EX_mem_to_reg, ID_EX_mem_read, ID_EX_mem_write,
              alu_ref(ID_EX_alu_op, a, b), b2, ID_EX_rd};
    end
    e.stall = m_stall;
    e.exm   = nxt;
    sb_q.push_back(e);
    m_exm = nxt;
    #3 obs_stall = ex_stall;
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] da, input logic [31:0] db,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    ID_EX_reg_write = 1'b1; ID_EX_mem_to_reg = 1'b0;
    ID_EX_mem_read  = 1'b0; ID_EX_mem_write  = 1'b0;
    ID_EX_alu_op = op; ID_EX_alu_src = 1'b0; ID_EX_imm = 32'd0;
    ID_EX_dataA = da; ID_EX_dataB = db;
    ID_EX_rs1 = rs1; ID_EX_rs2 = rs2; ID_EX_rd = rd;
  endtask

  task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string name);
    int nst, g;
    set_op(op, a, b, 5'd0, 5'd0, rd);
    nst = 0;
    g = 0;
    do begin
      step();
      if (obs_stall) nst++;
      g++;
    end while (m_stall && g < 200);
    check(name, 128'(nst), 128'(XLEN + 1));
  endtask

  initial begin : monitor
    exp_t e;
    exm_t got;
    logic s;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) continue;
      s = ex_stall;
      @(posedge clk);
      #2;
      e = sb_q.pop_front();
      got = '{EX_MEM_reg_write, EX_MEM_mem_to_reg, EX_MEM_mem_read, EX_MEM_mem_write,
              EX_MEM_alu_out, EX_MEM_dataB, EX_MEM_rd};
      check("stall", 128'(s), 128'(e.stall));
      check("ex_mem", 128'(got), 128'(e.exm));
    end
  end

  initial begin : driver
    reset = 1'b1; ex_flush = 1'b0;
    MEM_WB_reg_write = 1'b0; MEM_WB_rd = 5'd0; wb_data = 32'd0;
    set_op(4'd0, 32'd5, 32'd7, 5'd0, 5'd0, 5'd1);
    step();
    step();
    reset = 1'b0;
    step();

    // EX/MEM forward beats MEM/WB forward on rs1.
    set_op(4'd0, 32'h10, 32'd0, 5'd0, 5'd0, 5'd5);
    step();
    set_op(4'd1, 32'h77, 32'd3, 5'd5, 5'd0, 5'd6);
    MEM_WB_reg_write = 1'b1; MEM_WB_rd = 5'd5; wb_data = 32'h99;
    step();
    // Writes to x0 are never forwarded.
    set_op(4'd0, 32'h44, 32'd0, 5'd0, 5'd0, 5'd0);
    MEM_WB_rd = 5'd0;
    step();
    set_op(4'd1, 32'h20, 32'd3, 5'd0, 5'd0, 5'd7);
    step();
    MEM_WB_reg_write = 1'b0;

    set_op(4'd7, 32'h80000000, 32'd0, 5'd0, 5'd0, 5'd8);
    ID_EX_alu_src = 1'b1; ID_EX_imm = 32'h24;
    step();
    set_op(4'd4, 32'd1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd9);
    step();
    set_op(4'd3, 32'd1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd9);
    step();
    for (int op = 13; op < 16; op++) begin
      set_op(4'(op), 32'h1234, 32'h5678, 5'd0, 5'd0, 5'd2);
      step();
    end

    run_mul(4'd11, 32'd7, 32'd6, 5'd3, "mul_stall_len");
    run_mul(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, "mulhu_stall_len");
    run_mul(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, "mul_b2b_stall_len");

    // Flush in the tenth BUSY cycle.
    set_op(4'd11, 32'd9, 32'd9, 5'd0, 5'd0, 5'd3);
    step();
    repeat (9) step();
    ex_flush = 1'b1;
    step();
    check("flush_stall", 128'(obs_stall), 128'(0));
    ex_flush = 1'b0;
    set_op(4'd0, 32'd2, 32'd3, 5'd0, 5'd0, 5'd2);
    step();
    check("after_flush_stall", 128'(obs_stall), 128'(0));

    // Reset in the middle of a multiply.
    set_op(4'd11, 32'hABCD, 32'h1234, 5'd0, 5'd0, 5'd3);
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_mul(4'd11, 32'd3, 32'd5, 5'd3, "mul_after_reset_stall_len");

    // Random traffic; ID/EX is held while the model says the stage is stalled.
    for (int i = 0; i < 2500; i++) begin
      if (!m_stall) begin
        ID_EX_reg_write  = 1'($urandom);
        ID_EX_mem_to_reg = 1'($urandom);
        ID_EX_mem_read   = 1'($urandom);
        ID_EX_mem_write  = 1'($urandom);
        ID_EX_alu_op     = 4'($urandom_range(0, 15));
        ID_EX_alu_src    = 1'($urandom);
        ID_EX_dataA      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        ID_EX_dataB      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        ID_EX_imm        = $urandom;
        ID_EX_rs1        = 5'($urandom_range(0, 3));
        ID_EX_rs2        = 5'($urandom_range(0, 3));
        ID_EX_rd         = 5'($urandom_range(0, 3));
      end
      MEM_WB_reg_write = 1'($urandom);
      MEM_WB_rd        = 5'($urandom_range(0, 3));
      wb_data          = $urandom;
      ex_flush         = ($urandom_range(0, 59) == 0);
      reset            = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0; ex_flush = 1'b0;

    repeat (3) @(posedge clk);
    #5;
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
